// File: rtl/tmds_10b8b_dec_pkg.sv
// ----------------------------------------------------------------------------
// tmds_10b8b_dec_pkg
//   Shared definitions for the TMDS receive decoder:
//   - the four TMDS control-token code words (also used by the encoder side)
//   - the alignment FSM state encoding
//   - the per-word decode result structure
//   - a small popcount helper used by the coding-error check
//   No ports (package).
// ----------------------------------------------------------------------------
package tmds_10b8b_dec_pkg;

  // Control-token code words, indexed by the 2-bit control vector they carry.
  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } dec_state_e;

  typedef struct packed {
    logic       is_token;
    logic [1:0] c;
    logic [7:0] q;
    logic       code_err;
  } word_dec_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_10b8b_dec_word_dec.sv
// ----------------------------------------------------------------------------
// tmds_10b8b_dec_word_dec
//   Purely combinational decode of one raw 10-bit TMDS word.
//   Ports:
//     d    in  [9:0]  raw word: d[9]=invert flag, d[8]=XOR/XNOR flag, d[7:0]=payload
//     dec  out struct {is_token, c, q, code_err}
//          is_token : word is one of the four control tokens
//          c        : control vector carried by the token (00 when not a token)
//          q        : pixel data decoded from the word (always computed)
//          code_err : data word whose d[8] flag disagrees with its decoded ones count
// ----------------------------------------------------------------------------
module tmds_10b8b_dec_word_dec
  import tmds_10b8b_dec_pkg::*;
(
  input  logic [9:0] d,
  output word_dec_t  dec
);

  logic [7:0] x;
  logic [7:0] pix;
  logic [3:0] ones;
  logic       flag_expected;

  // Undo the optional inversion first, then undo the XOR/XNOR chain.
  assign x      = d[9] ? ~d[7:0] : d[7:0];
  assign pix[0] = x[0];

  for (genvar gi = 1; gi < 8; gi++) begin : g_chain
    assign pix[gi] = d[8] ? (x[gi] ^ x[gi-1]) : ~(x[gi] ^ x[gi-1]);
  end

  // The encoder picks XNOR for ones-heavy data (or exactly four ones with
  // bit 0 clear); any other d[8] value means the word was corrupted.
  assign ones          = popcount8(pix);
  assign flag_expected = ~((ones > 4'd4) || ((ones == 4'd4) && !pix[0]));

  always_comb begin
    dec.is_token = 1'b0;
    dec.c        = 2'b00;
    dec.q        = pix;
    case (d)
      TOK_C00: begin dec.is_token = 1'b1; dec.c = 2'b00; end
      TOK_C01: begin dec.is_token = 1'b1; dec.c = 2'b01; end
      TOK_C10: begin dec.is_token = 1'b1; dec.c = 2'b10; end
      TOK_C11: begin dec.is_token = 1'b1; dec.c = 2'b11; end
      default: ;
    endcase
    dec.code_err = !dec.is_token && (d[8] != flag_expected);
  end

endmodule

// File: rtl/tmds_10b8b_dec.sv
// ----------------------------------------------------------------------------
// tmds_10b8b_dec
//   TMDS receive decoder for one HDMI/DVI channel. Requests bit-slips from the
//   deserializer until control-token word alignment is found, then decodes each
//   word into pixel data or a control vector and flags coding errors.
//   Two-stage pipeline: stage 1 registers d, stage 2 registers the decode; the
//   alignment FSM acts on the stage-1 word.
//   Ports:
//     clk      in   word clock, one 10-bit word per cycle
//     rst      in   asynchronous reset, active-low
//     d        in   [9:0] raw TMDS word
//     q        out  [7:0] decoded pixel data, valid when den=1
//     c        out  [1:0] decoded control vector, valid when locked=1 and den=0
//     den      out  1 = q carries data
//     locked   out  word alignment achieved
//     bitslip  out  one-cycle request to shift the word boundary by one bit
//     err      out  one-cycle coding-error flag for the word at the outputs
// ----------------------------------------------------------------------------
module tmds_10b8b_dec
  import tmds_10b8b_dec_pkg::*;
#(
  parameter int LOCK_TOKENS   = 8,
  parameter int SEARCH_WINDOW = 1024,
  parameter int SLIP_WAIT     = 16,
  parameter int ERR_LIMIT     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] d,
  output logic [7:0] q,
  output logic [1:0] c,
  output logic       den,
  output logic       locked,
  output logic       bitslip,
  output logic       err
);

  localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
  localparam int TOK_W  = $clog2(LOCK_TOKENS) + 1;
  localparam int SLIP_W = $clog2(SLIP_WAIT) + 1;
  localparam int ERR_W  = $clog2(ERR_LIMIT) + 1;

  // Stage 1: raw word plus a valid flag so the reset value of the register is
  // never mistaken for a received word.
  logic [9:0] d1_q, d1_d;
  logic       v1_q, v1_d;

  dec_state_e        state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d, win_inc;
  logic [TOK_W-1:0]  tok_q, tok_d, tok_inc;
  logic [SLIP_W-1:0] slip_q, slip_d, slip_inc;
  logic [ERR_W-1:0]  errc_q, errc_d, errc_inc;

  logic [7:0] q_q, q_d;
  logic [1:0] c_q, c_d;
  logic       den_q, den_d;
  logic       locked_q, locked_d;
  logic       bitslip_q, bitslip_d;
  logic       err_q, err_d;

  word_dec_t dec;

  tmds_10b8b_dec_word_dec u_word_dec (
    .d   (d1_q),
    .dec (dec)
  );

  assign d1_d = d;
  assign v1_d = 1'b1;

  // Saturating increments: counters stick at all-ones rather than wrapping.
  assign win_inc  = (win_q  == {WIN_W{1'b1}})  ? win_q  : win_q  + WIN_W'(1);
  assign tok_inc  = (tok_q  == {TOK_W{1'b1}})  ? tok_q  : tok_q  + TOK_W'(1);
  assign slip_inc = (slip_q == {SLIP_W{1'b1}}) ? slip_q : slip_q + SLIP_W'(1);
  assign errc_inc = (errc_q == {ERR_W{1'b1}})  ? errc_q : errc_q + ERR_W'(1);

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    tok_d     = tok_q;
    slip_d    = slip_q;
    errc_d    = errc_q;
    q_d       = q_q;
    c_d       = c_q;
    den_d     = den_q;
    locked_d  = locked_q;
    bitslip_d = 1'b0;
    err_d     = 1'b0;

    if (v1_q) begin
      case (state_q)
        ST_SEARCH: begin
          q_d   = '0;
          c_d   = 2'b00;
          den_d = 1'b0;
          win_d = win_inc;
          tok_d = dec.is_token ? tok_inc : '0;
          if (dec.is_token && (tok_inc == TOK_W'(LOCK_TOKENS))) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            win_d    = '0;
            tok_d    = '0;
            errc_d   = '0;
          end else if (win_q == WIN_W'(SEARCH_WINDOW - 1)) begin
            state_d   = ST_SLIP;
            bitslip_d = 1'b1;
            win_d     = '0;
            tok_d     = '0;
            slip_d    = '0;
          end
        end

        // Words arriving while the deserializer settles are discarded.
        ST_SLIP: begin
          q_d    = '0;
          c_d    = 2'b00;
          den_d  = 1'b0;
          slip_d = slip_inc;
          if (slip_q == SLIP_W'(SLIP_WAIT - 1)) begin
            state_d = ST_SEARCH;
            slip_d  = '0;
            win_d   = '0;
            tok_d   = '0;
          end
        end

        ST_LOCKED: begin
          if (dec.is_token) begin
            den_d  = 1'b0;
            c_d    = dec.c;
            errc_d = '0;
          end else begin
            den_d = 1'b1;
            q_d   = dec.q;
            err_d = dec.code_err;
            if (dec.code_err) begin
              errc_d = errc_inc;
              // The limiting word is still presented with den=1/err=1.
              if (errc_inc == ERR_W'(ERR_LIMIT)) begin
                state_d  = ST_SEARCH;
                locked_d = 1'b0;
                errc_d   = '0;
                win_d    = '0;
                tok_d    = '0;
              end
            end
          end
        end

        default: begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
          win_d    = '0;
          tok_d    = '0;
          slip_d   = '0;
          errc_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1_q      <= '0;
      v1_q      <= 1'b0;
      state_q   <= ST_SEARCH;
      win_q     <= '0;
      tok_q     <= '0;
      slip_q    <= '0;
      errc_q    <= '0;
      q_q       <= '0;
      c_q       <= 2'b00;
      den_q     <= 1'b0;
      locked_q  <= 1'b0;
      bitslip_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      d1_q      <= d1_d;
      v1_q      <= v1_d;
      state_q   <= state_d;
      win_q     <= win_d;
      tok_q     <= tok_d;
      slip_q    <= slip_d;
      errc_q    <= errc_d;
      q_q       <= q_d;
      c_q       <= c_d;
      den_q     <= den_d;
      locked_q  <= locked_d;
      bitslip_q <= bitslip_d;
      err_q     <= err_d;
    end
  end

  assign q       = q_q;
  assign c       = c_q;
  assign den     = den_q;
  assign locked  = locked_q;
  assign bitslip = bitslip_q;
  assign err     = err_q;

endmodule

// File: tb/tb_tmds_10b8b_dec.sv
// ----------------------------------------------------------------------------
// tb_tmds_10b8b_dec
//   Drives directed and random word streams into tmds_10b8b_dec and compares
//   every output word against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_tmds_10b8b_dec;

  localparam int LOCK_TOKENS   = 8;
  localparam int SEARCH_WINDOW = 1024;
  localparam int SLIP_WAIT     = 16;
  localparam int ERR_LIMIT     = 4;

  localparam int MS_SEARCH = 0;
  localparam int MS_SLIP   = 1;
  localparam int MS_LOCKED = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] d   = '0;
  logic [7:0] q;
  logic [1:0] c;
  logic       den, locked, bitslip, err;
  logic [13:0] outs;

  always #5 clk = ~clk;

  tmds_10b8b_dec #(
    .LOCK_TOKENS   (LOCK_TOKENS),
    .SEARCH_WINDOW (SEARCH_WINDOW),
    .SLIP_WAIT     (SLIP_WAIT),
    .ERR_LIMIT     (ERR_LIMIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .q       (q),
    .c       (c),
    .den     (den),
    .locked  (locked),
    .bitslip (bitslip),
    .err     (err)
  );

  assign outs = {locked, bitslip, den, err, c, q};

  int n_checks = 0;
  int n_fail   = 0;
  int n_slip   = 0;
  int n_words  = 0;

  // Reference model state
  int         m_mode, m_words, m_toks, m_slip_run, m_err_run;
  logic [7:0] m_q;
  logic [1:0] m_c;
  logic [13:0] exp_q[$];
  logic [9:0]  toks[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s word=%0d got=%h expected=%h", tag, n_words, got, want);
    end
  endtask

  function automatic int tok_code(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (toks[i] == w) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ref_pixel(input logic [9:0] w);
    logic [7:0] x, r;
    x = w[7:0];
    if (w[9]) x = ~x;
    r[0] = x[0];
    // XOR-coded bits equal 1 where neighbours differ; XNOR-coded where equal.
    for (int i = 1; i < 8; i++) r[i] = ((x[i] != x[i-1]) == w[8]);
    return r;
  endfunction

  function automatic bit ref_err(input logic [9:0] w, input logic [7:0] px);
    int n;
    bit want;
    n = $countones(px);
    want = !((n > 4) || (n == 4 && px[0] == 1'b0));
    return w[8] != want;
  endfunction

  task automatic model_reset();
    m_mode = MS_SEARCH; m_words = 0; m_toks = 0; m_slip_run = 0; m_err_run = 0;
    m_q = '0; m_c = '0;
  endtask

  task automatic model_word(input logic [9:0] w, output logic [13:0] e);
    int code;
    logic [7:0] px;
    bit perr, bs, ep, dn;
    code = tok_code(w);
    px   = ref_pixel(w);
    perr = ref_err(w, px);
    bs = 0; ep = 0; dn = 0;
    if (m_mode == MS_LOCKED) begin
      if (code >= 0) begin
        m_err_run = 0;
        m_c = 2'(code);
      end else begin
        dn = 1; m_q = px; ep = perr;
        if (perr) begin
          m_err_run++;
          if (m_err_run >= ERR_LIMIT) begin
            m_mode = MS_SEARCH; m_err_run = 0; m_words = 0; m_toks = 0;
          end
        end
      end
    end else begin
      m_q = '0; m_c = '0;
      if (m_mode == MS_SLIP) begin
        m_slip_run++;
        if (m_slip_run >= SLIP_WAIT) begin
          m_mode = MS_SEARCH; m_slip_run = 0; m_words = 0; m_toks = 0;
        end
      end else begin
        m_words++;
        m_toks = (code >= 0) ? m_toks + 1 : 0;
        if (m_toks >= LOCK_TOKENS) begin
          m_mode = MS_LOCKED; m_words = 0; m_toks = 0; m_err_run = 0;
        end else if (m_words >= SEARCH_WINDOW) begin
          m_mode = MS_SLIP; bs = 1; m_words = 0; m_toks = 0; m_slip_run = 0;
        end
      end
    end
    e = {(m_mode == MS_LOCKED), bs, dn, ep, m_c, m_q};
  endtask

  // Called at a falling edge: check the word sent two cycles ago, send a new one.
  task automatic tick(input logic [9:0] w);
    logic [13:0] e;
    if (bitslip) n_slip++;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check_eq("out", 32'(outs), 32'(e));
    end
    d = w;
    model_word(w, e);
    exp_q.push_back(e);
    n_words++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    d   = '0;
    exp_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    n_slip = 0;
  endtask

  task automatic send_n(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) tick(w);
  endtask

  task automatic rand_traffic(input int n, input int tok_pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        for (int k = 0; k < LOCK_TOKENS; k++) tick(toks[$urandom_range(0, 3)]);
      end else if ($urandom_range(0, 99) < tok_pct) begin
        tick(toks[$urandom_range(0, 3)]);
      end else begin
        tick(10'($urandom_range(0, 1023)));
      end
    end
  endtask

  initial begin
    toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
    model_reset();
    #1;
    check_eq("reset_outs", 32'(outs), 32'(0));
    do_reset();

    // Lock on eight 0x354 tokens
    send_n(10'h354, 10);
    check_eq("lock_after_8", 32'(locked), 32'(1));

    // Data word then a token
    tick(10'h100);
    tick(10'h2AB);
    send_n(10'h354, 2);

    // Errors interrupted by a token keep lock
    send_n(10'h155, 3);
    tick(10'h0AB);
    send_n(10'h155, 3);
    send_n(10'h2AB, 2);
    check_eq("lock_kept", 32'(locked), 32'(1));

    // Four errors in a row drop lock
    send_n(10'h155, 4);
    send_n(10'h100, 2);
    check_eq("lock_lost", 32'(locked), 32'(0));

    // Relock and run random traffic
    send_n(10'h154, 8);
    rand_traffic(400, 40);

    // Search window expiry: one bitslip, tokens during settle are ignored
    do_reset();
    send_n(10'h3FF, SEARCH_WINDOW);
    send_n(10'h354, SLIP_WAIT + LOCK_TOKENS + 2);
    check_eq("slip_count", 32'(n_slip), 32'(1));
    check_eq("relock_after_slip", 32'(locked), 32'(1));

    // Async reset in the middle of data
    rand_traffic(50, 60);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_reset_outs", 32'(outs), 32'(0));
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_n(10'h354, 7);
    send_n(10'h100, 2);
    check_eq("no_lock_7", 32'(locked), 32'(0));
    send_n(10'h354, 10);
    check_eq("relock_8", 32'(locked), 32'(1));

    // Mostly random stream from reset, includes slips and relocks
    do_reset();
    rand_traffic(1500, 50);
    send_n(10'h354, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
